// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters A/B, decodes x4 into a signed position,
// and reports the number of valid steps in each fixed gate window.
module quad_decoder #(
  parameter int          WIDTH    = 32,
  parameter int          FILT_LEN = 4,
  parameter logic [31:0] GATE_CYC = 32'd1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    clr,
  output logic signed [WIDTH-1:0] pos_cnt,
  output logic                    dir,
  output logic                    step_pulse,
  output logic                    err_pulse,
  output logic                    err_flag,
  output logic [WIDTH-1:0]        speed_cnt,
  output logic                    speed_vld
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [3:0]  FILT_N    = 4'(FILT_LEN);
  localparam logic [31:0] GATE_LAST = GATE_CYC - 32'd1;

  logic             r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic             r_vld_s1, r_vld_s2;
  logic [1:0]       w_sync;
  logic [1:0]       r_cand;
  logic [3:0]       r_fcnt, w_fcnt_next;
  logic [1:0]       r_filt;
  logic             r_filt_vld;
  state_t           r_state;
  logic [1:0]       r_prev;
  logic [1:0]       w_delta;
  logic [WIDTH-1:0] r_pos;
  logic             r_dir, r_step, r_err, r_err_flag;
  logic [31:0]      r_gate_cnt;
  logic [WIDTH-1:0] r_edge_cnt, w_edge_sum;
  logic [WIDTH-1:0] r_speed;
  logic             r_speed_vld;

  // Position along the forward cycle 00->10->11->01 for an {A,B} pair.
  function automatic logic [1:0] ab_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  assign w_sync  = {r_a_s2, r_b_s2};
  assign w_delta = ab_idx(r_filt) - ab_idx(r_prev);

  // The valid shift keeps the reset-zero sync contents from being accepted as a real value.
  always_comb begin
    w_fcnt_next = r_fcnt;
    if (!r_vld_s2)
      w_fcnt_next = 4'd0;
    else if (w_sync != r_cand || r_fcnt == 4'd0)
      w_fcnt_next = 4'd1;
    else if (r_fcnt < FILT_N)
      w_fcnt_next = r_fcnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_s1     <= 1'b0;
      r_a_s2     <= 1'b0;
      r_b_s1     <= 1'b0;
      r_b_s2     <= 1'b0;
      r_vld_s1   <= 1'b0;
      r_vld_s2   <= 1'b0;
      r_cand     <= 2'b00;
      r_fcnt     <= 4'd0;
      r_filt     <= 2'b00;
      r_filt_vld <= 1'b0;
    end else begin
      r_a_s1   <= enc_a;
      r_a_s2   <= r_a_s1;
      r_b_s1   <= enc_b;
      r_b_s2   <= r_b_s1;
      r_vld_s1 <= 1'b1;
      r_vld_s2 <= r_vld_s1;
      r_cand   <= w_sync;
      r_fcnt   <= w_fcnt_next;
      if (w_fcnt_next == FILT_N) begin
        r_filt     <= w_sync;
        r_filt_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_prev     <= 2'b00;
      r_pos      <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_err      <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_filt_vld) begin
            r_prev  <= r_filt;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_filt != r_prev) begin
            r_prev <= r_filt;
            case (w_delta)
              2'd1: begin
                r_step <= 1'b1;
                r_dir  <= 1'b1;
                r_pos  <= r_pos + WIDTH'(1);
              end
              2'd3: begin
                r_step <= 1'b1;
                r_dir  <= 1'b0;
                r_pos  <= r_pos - WIDTH'(1);
              end
              default: begin
                r_err      <= 1'b1;
                r_err_flag <= 1'b1;
              end
            endcase
          end
        end
        default: r_state <= S_INIT;
      endcase
      // clr overrides any step or error landing in the same cycle.
      if (clr) begin
        r_pos      <= '0;
        r_err_flag <= 1'b0;
      end
    end
  end

  assign w_edge_sum = (r_step && r_edge_cnt != '1) ? r_edge_cnt + WIDTH'(1) : r_edge_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_cnt  <= 32'd0;
      r_edge_cnt  <= '0;
      r_speed     <= '0;
      r_speed_vld <= 1'b0;
    end else begin
      r_speed_vld <= 1'b0;
      if (r_gate_cnt == GATE_LAST) begin
        r_gate_cnt  <= 32'd0;
        r_speed     <= w_edge_sum;
        r_speed_vld <= 1'b1;
        r_edge_cnt  <= '0;
      end else begin
        r_gate_cnt <= r_gate_cnt + 32'd1;
        r_edge_cnt <= w_edge_sum;
      end
    end
  end

  assign pos_cnt    = r_pos;
  assign dir        = r_dir;
  assign step_pulse = r_step;
  assign err_pulse  = r_err;
  assign err_flag   = r_err_flag;
  assign speed_cnt  = r_speed;
  assign speed_vld  = r_speed_vld;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomised bench for quad_decoder: an encoder-phase model predicts position, direction,
// pulse counts and gate-window speed results.
module tb_quad_decoder;

  logic        clk = 1'b0;
  logic        rst, enc_a, enc_b, clr;
  logic [31:0] pos_cnt;
  logic        dir, step_pulse, err_pulse, err_flag;
  logic [31:0] speed_cnt;
  logic        speed_vld;

  quad_decoder #(.WIDTH(32), .FILT_LEN(4), .GATE_CYC(32'd100)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .pos_cnt(pos_cnt), .dir(dir), .step_pulse(step_pulse), .err_pulse(err_pulse),
    .err_flag(err_flag), .speed_cnt(speed_cnt), .speed_vld(speed_vld)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;
  int cyc = 0, n_steps = 0, n_errs = 0, rel_cyc = 0;
  int spd_val_q[$], spd_cyc_q[$];
  logic [1:0]  seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          gen_idx = 0;
  logic [31:0] exp_pos = 0;
  logic        exp_dir = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (step_pulse) n_steps++;
      if (err_pulse) n_errs++;
      if (speed_vld) begin
        spd_val_q.push_back(int'(speed_cnt));
        spd_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One encoder edge in the chosen direction, then hold for the given number of cycles.
  task automatic gen_step(input bit fwd, input int hold);
    gen_idx = fwd ? (gen_idx + 1) % 4 : (gen_idx + 3) % 4;
    {enc_a, enc_b} = seq[gen_idx];
    exp_pos = fwd ? exp_pos + 32'd1 : exp_pos - 32'd1;
    exp_dir = fwd;
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    int s0, e0;
    logic [31:0] p0;
    rst = 1'b1; clr = 1'b0; enc_a = 1'b1; enc_b = 1'b1;
    gen_idx = 2;
    repeat (5) @(negedge clk);
    chk("rst_pos", pos_cnt, 0);
    chk("rst_dir", dir, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_errflag", err_flag, 0);
    chk("rst_speed", speed_cnt, 0);
    chk("rst_speed_vld", speed_vld, 0);

    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rel_no_step", n_steps, 0);
    chk("rel_no_err", n_errs, 0);
    chk("rel_pos", pos_cnt, 0);

    s0 = n_steps;
    for (int i = 0; i < 40; i++) gen_step(1'b1, $urandom_range(10, 20));
    chk("fwd_pos", pos_cnt, exp_pos);
    chk("fwd_pos40", pos_cnt, 40);
    chk("fwd_dir", dir, 1);
    chk("fwd_steps", n_steps - s0, 40);
    chk("fwd_errflag", err_flag, 0);

    for (int i = 0; i < 6; i++) gen_step(1'b0, $urandom_range(10, 20));
    chk("rev_pos34", pos_cnt, 34);
    chk("rev_dir", dir, 0);

    // Edge change reaches step_pulse on the 7th rising edge (2 sync + 4 filter + 1 decode).
    gen_idx = (gen_idx + 3) % 4;
    {enc_a, enc_b} = seq[gen_idx];
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("lat_no_step_yet", step_pulse, 0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_step_seen", step_pulse, 1);
    chk("clr_pos", pos_cnt, 0);
    @(negedge clk);
    clr = 1'b0;
    exp_pos = 0; exp_dir = 0;
    repeat (10) @(negedge clk);
    chk("clr_pos_hold", pos_cnt, 0);

    s0 = n_steps; e0 = n_errs;
    enc_a = ~enc_a;
    repeat (2) @(negedge clk);
    enc_a = ~enc_a;
    repeat (20) @(negedge clk);
    chk("glitch_steps", n_steps - s0, 0);
    chk("glitch_errs", n_errs - e0, 0);
    chk("glitch_pos", pos_cnt, exp_pos);

    enc_a = ~enc_a; enc_b = ~enc_b;
    gen_idx = (gen_idx + 2) % 4;
    repeat (15) @(negedge clk);
    chk("dbl_errs", n_errs - e0, 1);
    chk("dbl_steps", n_steps - s0, 0);
    chk("dbl_errflag", err_flag, 1);
    chk("dbl_pos", pos_cnt, exp_pos);
    chk("dbl_dir", dir, exp_dir);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_errflag", err_flag, 0);
    gen_step(1'b0, 12);
    chk("wrap_down", pos_cnt, 32'hFFFF_FFFF);
    gen_step(1'b1, 12);
    chk("wrap_up", pos_cnt, 32'h0000_0000);

    e0 = n_errs;
    for (int i = 0; i < 30; i++) begin
      gen_step(1'($urandom_range(0, 1)), $urandom_range(10, 25));
      chk("walk_pos", pos_cnt, exp_pos);
      chk("walk_dir", dir, exp_dir);
    end
    chk("walk_errs", n_errs - e0, 0);

    // Speed: one edge every 10 clk, reset asserted mid-window.
    fork
      begin
        for (int k = 0; k < 80; k++) gen_step(1'b1, 10);
      end
      begin
        repeat (255) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("spd_rst_cnt", speed_cnt, 0);
        chk("spd_rst_vld", speed_vld, 0);
        spd_val_q.delete();
        spd_cyc_q.delete();
        rst = 1'b0;
        rel_cyc = cyc;
      end
    join
    repeat (5) @(negedge clk);
    chk("spd_events", spd_cyc_q.size(), 5);
    if (spd_cyc_q.size() > 0) chk("spd_first_lat", spd_cyc_q[0] - rel_cyc, 100);
    for (int i = 1; i < spd_cyc_q.size(); i++) begin
      chk("spd_period", spd_cyc_q[i] - spd_cyc_q[i-1], 100);
      chk("spd_value", spd_val_q[i], 10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
